// File: rtl/frame_buffer_pkg.sv
// Shared types and constants for the triple-buffered frame scheduler.
package frame_buffer_pkg;

  localparam int NUM_BUFS  = 3;
  localparam int BUF_IDX_W = 2;

  typedef logic [BUF_IDX_W-1:0] buf_idx_t;

  typedef enum logic [1:0] {W_IDLE, W_START, W_BUSY} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_BUSY} r_state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Frame size and per-buffer DDR base address computation for writer and reader.
module fb_addr_gen
  import frame_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [31:0]           hres_i,
  input  logic [31:0]           vres_i,
  input  buf_idx_t              wr_idx_i,
  input  buf_idx_t              rd_idx_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o
);

  logic [ADDR_WIDTH-1:0] frame_bytes;

  // 4 bytes per pixel; everything wraps modulo 2^ADDR_WIDTH
  assign frame_bytes = (ADDR_WIDTH'(hres_i) * ADDR_WIDTH'(vres_i)) << 2;
  assign wr_addr_o   = base_addr_i + ADDR_WIDTH'(wr_idx_i) * frame_bytes;
  assign rd_addr_o   = base_addr_i + ADDR_WIDTH'(rd_idx_i) * frame_bytes;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer writer/reader scheduler for DDR frame engines.
// Define FB_STATS_EN to add the frames_dropped / frames_repeated counters.
//
// state   | meaning
// W_IDLE  | writer waits for enable
// W_START | start_write pulse, target buffer chosen
// W_BUSY  | write engine filling wr_idx, wait write_done
// R_IDLE  | reader waits for enable and a complete frame
// R_START | start_read pulse, rd_idx <= latest_idx
// R_BUSY  | read engine draining rd_idx, wait read_done
module frame_buffer_scheduler
  import frame_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BUFS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           hres,
  input  logic [31:0]           vres,
  input  logic                  write_done,
  input  logic                  read_done,
  output logic                  start_write,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] write_buf,
  output logic [ADDR_WIDTH-1:0] read_buf,
  output logic [31:0]           hres_out,
  output logic [31:0]           vres_out,
  output logic                  frame_valid
`ifdef FB_STATS_EN
  ,
  output logic [15:0]           frames_dropped,
  output logic [15:0]           frames_repeated
`endif
);

  logic                  enable_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           hres_q;
  logic [31:0]           vres_q;
  w_state_e              w_state_q;
  r_state_e              r_state_q;
  buf_idx_t              wr_idx_q;
  buf_idx_t              rd_idx_q;
  buf_idx_t              latest_idx_q;
  logic                  fresh_q;
  logic                  frame_valid_q;

  buf_idx_t              wr_pick;
  buf_idx_t              wr_sel;
  buf_idx_t              rd_sel;
  logic                  wr_commit;

  // Lowest buffer that is neither being read nor holding the newest frame
  always_comb begin
    wr_pick = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (buf_idx_t'(i) != rd_idx_q &&
          (!frame_valid_q || buf_idx_t'(i) != latest_idx_q))
        wr_pick = buf_idx_t'(i);
    end
  end

  assign wr_sel    = (w_state_q == W_START) ? wr_pick : wr_idx_q;
  assign rd_sel    = (r_state_q == R_START) ? latest_idx_q : rd_idx_q;
  assign wr_commit = (w_state_q == W_BUSY) && write_done;

  fb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .base_addr_i (base_q),
    .hres_i      (hres_q),
    .vres_i      (vres_q),
    .wr_idx_i    (wr_sel),
    .rd_idx_i    (rd_sel),
    .wr_addr_o   (write_buf),
    .rd_addr_o   (read_buf)
  );

  assign start_write = (w_state_q == W_START);
  assign start_read  = (r_state_q == R_START);
  assign hres_out    = hres_q;
  assign vres_out    = vres_q;
  assign frame_valid = frame_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q      <= 1'b0;
      base_q        <= '0;
      hres_q        <= '0;
      vres_q        <= '0;
      w_state_q     <= W_IDLE;
      r_state_q     <= R_IDLE;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      latest_idx_q  <= '0;
      fresh_q       <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      enable_q <= enable;
      if (enable && !enable_q) begin
        base_q <= base_addr;
        hres_q <= hres;
        vres_q <= vres;
      end

      case (w_state_q)
        W_IDLE:  if (enable) w_state_q <= W_START;
        W_START: begin
          wr_idx_q  <= wr_pick;
          w_state_q <= W_BUSY;
        end
        W_BUSY: if (write_done) begin
          latest_idx_q  <= wr_idx_q;
          frame_valid_q <= 1'b1;
          w_state_q     <= enable ? W_START : W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase

      case (r_state_q)
        R_IDLE:  if (enable && frame_valid_q) r_state_q <= R_START;
        R_START: begin
          rd_idx_q  <= latest_idx_q;
          r_state_q <= R_BUSY;
        end
        R_BUSY:  if (read_done) r_state_q <= enable ? R_START : R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase

      // A frame landing in the same cycle the reader starts is still unread
      if (wr_commit)
        fresh_q <= 1'b1;
      else if (r_state_q == R_START)
        fresh_q <= 1'b0;
    end
  end

`ifdef FB_STATS_EN
  logic [15:0] dropped_q;
  logic [15:0] repeated_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropped_q  <= '0;
      repeated_q <= '0;
    end else begin
      if (wr_commit && fresh_q && dropped_q != 16'hFFFF)
        dropped_q <= dropped_q + 16'd1;
      if (r_state_q == R_START && !fresh_q && repeated_q != 16'hFFFF)
        repeated_q <= repeated_q + 16'd1;
    end
  end

  assign frames_dropped  = dropped_q;
  assign frames_repeated = repeated_q;
`endif

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Scoreboard bench: script pushes expected engine start addresses, monitor pops on each start pulse.
module tb_frame_buffer_scheduler;

  localparam logic [31:0] B0 = 32'h1000_0000;
  localparam logic [31:0] B1 = 32'h1000_0020;
  localparam logic [31:0] B2 = 32'h1000_0040;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] base_addr;
  logic [31:0] hres;
  logic [31:0] vres;
  logic        write_done;
  logic        read_done;
  logic        start_write;
  logic        start_read;
  logic [31:0] write_buf;
  logic [31:0] read_buf;
  logic [31:0] hres_out;
  logic [31:0] vres_out;
  logic        frame_valid;
`ifdef FB_STATS_EN
  logic [15:0] frames_dropped;
  logic [15:0] frames_repeated;
`endif

  frame_buffer_scheduler #(.ADDR_WIDTH(32), .NUM_BUFS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .base_addr   (base_addr),
    .hres        (hres),
    .vres        (vres),
    .write_done  (write_done),
    .read_done   (read_done),
    .start_write (start_write),
    .start_read  (start_read),
    .write_buf   (write_buf),
    .read_buf    (read_buf),
    .hres_out    (hres_out),
    .vres_out    (vres_out),
    .frame_valid (frame_valid)
`ifdef FB_STATS_EN
    ,
    .frames_dropped  (frames_dropped),
    .frames_repeated (frames_repeated)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_wr[$];
  logic [31:0] exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected addresses on start pulses, checks pulse width,
  // address stability while an engine is busy, and writer/reader separation.
  logic        wr_busy, rd_busy, prev_sw, prev_sr;
  logic [31:0] wr_cur, rd_cur;

  initial begin
    wr_busy = 0; rd_busy = 0; prev_sw = 0; prev_sr = 0;
    wr_cur = '0; rd_cur = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        wr_busy = 0; rd_busy = 0; prev_sw = 0; prev_sr = 0;
      end else begin
        if (prev_sw) check("start_write_width", {31'd0, start_write}, 32'd0);
        if (prev_sr) check("start_read_width", {31'd0, start_read}, 32'd0);
        if (wr_busy) check("write_buf_stable", write_buf, wr_cur);
        if (rd_busy) check("read_buf_stable", read_buf, rd_cur);
        if (wr_busy && rd_busy) begin
          n_checks++;
          if (write_buf != read_buf) n_pass++;
          else $display("FAIL wr_rd_overlap: write_buf 0x%08h equals read_buf 0x%08h", write_buf, read_buf);
        end
        if (write_done && wr_busy) wr_busy = 0;
        if (read_done && rd_busy) rd_busy = 0;
        if (start_write) begin
          if (exp_wr.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_start_write: actual write_buf 0x%08h required no pulse", write_buf);
          end else check("write_buf", write_buf, exp_wr.pop_front());
          wr_busy = 1; wr_cur = write_buf;
        end
        if (start_read) begin
          if (exp_rd.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_start_read: actual read_buf 0x%08h required no pulse", read_buf);
          end else check("read_buf", read_buf, exp_rd.pop_front());
          rd_busy = 1; rd_cur = read_buf;
        end
        prev_sw = start_write;
        prev_sr = start_read;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_start_write"}, {31'd0, start_write}, 32'd0);
    check({tag, "_start_read"},  {31'd0, start_read},  32'd0);
    check({tag, "_write_buf"},   write_buf, 32'd0);
    check({tag, "_read_buf"},    read_buf,  32'd0);
    check({tag, "_hres_out"},    hres_out,  32'd0);
    check({tag, "_vres_out"},    vres_out,  32'd0);
    check({tag, "_frame_valid"}, {31'd0, frame_valid}, 32'd0);
`ifdef FB_STATS_EN
    check({tag, "_frames_dropped"},  {16'd0, frames_dropped},  32'd0);
    check({tag, "_frames_repeated"}, {16'd0, frames_repeated}, 32'd0);
`endif
  endtask

  initial begin
    reset = 0; enable = 0; write_done = 0; read_done = 0;
    base_addr = B0; hres = 32'd4; vres = 32'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("por");
    tick(); reset = 1;
    tick(); tick();

    // c0: enable rises; first target is buffer 1 since rd_idx=0
    exp_wr.push_back(B1);
    enable = 1;
    tick();                                       // c1 W_START
    tick();                                       // c2 W_BUSY
    check("fv_before_done", {31'd0, frame_valid}, 32'd0);
    write_done = 1;
    exp_wr.push_back(B2);
    exp_rd.push_back(B1);
    tick(); write_done = 0;                       // c3
    check("fv_after_done", {31'd0, frame_valid}, 32'd1);
    check("hres_out", hres_out, 32'd4);
    check("vres_out", vres_out, 32'd2);

    // writer three frames per reader frame (reader on B1 c5..c10)
    tick(); tick(); write_done = 1; exp_wr.push_back(B0);   // c5
    tick(); write_done = 0;                                  // c6
    tick(); write_done = 1; exp_wr.push_back(B2);            // c7
    tick(); write_done = 0;                                  // c8
    tick(); write_done = 1; exp_wr.push_back(B0);            // c9
    tick(); write_done = 0; read_done = 1; exp_rd.push_back(B2); // c10
    tick(); read_done = 0;                                   // c11 R_START B2

    // writer stalls on B0; reader repeats B2
    tick(); read_done = 1; exp_rd.push_back(B2);             // c12
    tick(); read_done = 0;                                   // c13
    tick(); read_done = 1; exp_rd.push_back(B2);             // c14
    tick(); read_done = 0;                                   // c15
    tick(); read_done = 1; exp_rd.push_back(B2);             // c16

    // write_done lands on the R_START cycle: that read keeps B2, next gets B0
    tick(); read_done = 0; write_done = 1; exp_wr.push_back(B1); // c17
    tick(); write_done = 0; read_done = 1; exp_rd.push_back(B0); // c18
    tick(); read_done = 0;                                   // c19
    tick();                                                  // c20 both busy
`ifdef FB_STATS_EN
    check("frames_dropped", {16'd0, frames_dropped}, 32'd2);
    check("frames_repeated", {16'd0, frames_repeated}, 32'd3);
`endif
    reset = 0;
    @(negedge clk);
    check_all_zero("midframe_rst");
    tick();

    // restart from power-up state; stale completions must be ignored
    tick(); reset = 1; write_done = 1; read_done = 1; exp_wr.push_back(B1); // r0
    tick(); read_done = 0;                                   // r1 W_START
    tick(); write_done = 0; enable = 0;                      // r2
    check("fv_stale_done", {31'd0, frame_valid}, 32'd0);
    tick(); write_done = 1;                                  // r3
    tick(); write_done = 0;                                  // r4
    check("fv_after_restart", {31'd0, frame_valid}, 32'd1);
    repeat (6) tick();
    check("idle_write_buf", write_buf, B1);
    check("idle_read_buf", read_buf, B0);
    check("wr_queue_drained", exp_wr.size(), 32'd0);
    check("rd_queue_drained", exp_rd.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
